// File: rtl/toplayici_4bit_pkg.sv
// Shared constants and the single-bit full-add helper for the toplayici_4bit adder.
// Optional macro TOPLAYICI_4BIT_OVF_EN adds signed-overflow outputs to the top.
package toplayici_4bit_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic co;
    logic s;
  } fa_result_t;

  function automatic fa_result_t full_add(input logic a, input logic b, input logic ci);
    fa_result_t r;
    r.s  = a ^ b ^ ci;
    r.co = (a & b) | (a & ci) | (b & ci);
    return r;
  endfunction

endpackage

// File: rtl/toplayici_4bit_full_adder.sv
// One full-adder cell; the top chains WIDTH of these into a ripple-carry adder.
module full_adder
  import toplayici_4bit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  fa_result_t res;

  assign res = full_add(a, b, ci);
  assign s   = res.s;
  assign co  = res.co;

endmodule

// File: rtl/toplayici_4bit.sv
// Ripple-carry adder with a combinational sum and a one-cycle registered copy.
// Define TOPLAYICI_4BIT_OVF_EN to add the ovf/ovf_q signed-overflow outputs.
module toplayici_4bit
  import toplayici_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [WIDTH-1:0] S_q,
  output logic             Cout_q,
  output logic             out_valid
`ifdef TOPLAYICI_4BIT_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             valid_d, valid_q;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (S[i]),
      .co (carry[i+1])
    );
  end

  assign Cout = carry[WIDTH];

  // Registered copy only updates on qualified input; otherwise it holds.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = S;
      cout_d = Cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign S_q       = sum_q;
  assign Cout_q    = cout_q;
  assign out_valid = valid_q;

`ifdef TOPLAYICI_4BIT_OVF_EN
  logic ovf_d;

  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf = carry[WIDTH-1] ^ carry[WIDTH];

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
`endif

endmodule

// File: tb/tb_toplayici_4bit.sv
// Directed self-checking bench for toplayici_4bit at WIDTH=4.
// Define TOPLAYICI_4BIT_OVF_EN to also check the overflow outputs.
module tb_toplayici_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic       in_valid;
  logic [3:0] S;
  logic       Cout;
  logic [3:0] S_q;
  logic       Cout_q;
  logic       out_valid;
`ifdef TOPLAYICI_4BIT_OVF_EN
  logic       ovf;
  logic       ovf_q;
`endif

  int compare_count = 0;
  int fail_count    = 0;

  toplayici_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .in_valid  (in_valid),
    .S         (S),
    .Cout      (Cout),
    .S_q       (S_q),
    .Cout_q    (Cout_q),
    .out_valid (out_valid)
`ifdef TOPLAYICI_4BIT_OVF_EN
    ,
    .ovf       (ovf),
    .ovf_q     (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic cin, input logic valid);
    A        = a;
    B        = b;
    Cin      = cin;
    in_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    #2;
    checkOutput("reset_S_q", 32'(S_q), 32'h0);
    checkOutput("reset_Cout_q", 32'(Cout_q), 32'h0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_S", 32'(S), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive combinational check against plain integer addition
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          applyStimulus(4'(a), 4'(b), 1'(c), 1'b0);
          #1;
          checkOutput("exhaustive_sum", 32'({Cout, S}), 32'(a + b + c));
        end
      end
    end

    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0); #1;
    checkOutput("corner_zero_S", 32'(S), 32'h0);
    checkOutput("corner_zero_Cout", 32'(Cout), 32'h0);
    applyStimulus(4'hF, 4'hF, 1'b1, 1'b0); #1;
    checkOutput("corner_max_S", 32'(S), 32'hF);
    checkOutput("corner_max_Cout", 32'(Cout), 32'h1);
    applyStimulus(4'h8, 4'h8, 1'b0, 1'b0); #1;
    checkOutput("corner_msb_S", 32'(S), 32'h0);
    checkOutput("corner_msb_Cout", 32'(Cout), 32'h1);

    // Registered path: load then hold
    @(negedge clk);
    applyStimulus(4'h3, 4'h5, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkOutput("reg_load_S_q", 32'(S_q), 32'h9);
    checkOutput("reg_load_Cout_q", 32'(Cout_q), 32'h0);
    checkOutput("reg_load_valid", 32'(out_valid), 32'h1);
    applyStimulus(4'h1, 4'hF, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("reg_hold_valid", 32'(out_valid), 32'h0);
    checkOutput("reg_hold_S_q", 32'(S_q), 32'h9);
    checkOutput("reg_hold_Cout_q", 32'(Cout_q), 32'h0);

    // Back-to-back results, one per cycle
    applyStimulus(4'h4, 4'h4, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("b2b_0_S_q", 32'(S_q), 32'h8);
    checkOutput("b2b_0_valid", 32'(out_valid), 32'h1);
    applyStimulus(4'hF, 4'h2, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("b2b_1_S_q", 32'(S_q), 32'h1);
    checkOutput("b2b_1_Cout_q", 32'(Cout_q), 32'h1);
    checkOutput("b2b_1_valid", 32'(out_valid), 32'h1);
    applyStimulus(4'h6, 4'h7, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("b2b_2_S_q", 32'(S_q), 32'hD);
    checkOutput("b2b_2_Cout_q", 32'(Cout_q), 32'h0);
    checkOutput("b2b_2_valid", 32'(out_valid), 32'h1);

    // Asynchronous reset between edges while a result is valid
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_S_q", 32'(S_q), 32'h0);
    checkOutput("rst_async_Cout_q", 32'(Cout_q), 32'h0);
    checkOutput("rst_async_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_comb_S", 32'({Cout, S}), 32'hD);
    @(posedge clk); #1;
    checkOutput("rst_held_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_held_S_q", 32'(S_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'h6, 4'h7, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("post_rst_idle_valid", 32'(out_valid), 32'h0);
    checkOutput("post_rst_idle_S_q", 32'(S_q), 32'h0);
    applyStimulus(4'h2, 4'h2, 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("post_rst_S_q", 32'(S_q), 32'h4);
    checkOutput("post_rst_valid", 32'(out_valid), 32'h1);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);

`ifdef TOPLAYICI_4BIT_OVF_EN
    @(negedge clk);
    applyStimulus(4'h7, 4'h1, 1'b0, 1'b1); #1;
    checkOutput("ovf_pos_S", 32'(S), 32'h8);
    checkOutput("ovf_pos_ovf", 32'(ovf), 32'h1);
    @(posedge clk); #1;
    checkOutput("ovf_pos_ovf_q", 32'(ovf_q), 32'h1);
    applyStimulus(4'hF, 4'h1, 1'b0, 1'b1); #1;
    checkOutput("ovf_none_S", 32'(S), 32'h0);
    checkOutput("ovf_none_Cout", 32'(Cout), 32'h1);
    checkOutput("ovf_none_ovf", 32'(ovf), 32'h0);
    @(posedge clk); #1;
    checkOutput("ovf_none_ovf_q", 32'(ovf_q), 32'h0);
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
